counter_seq_detector: RTL and testbench

- Second-generation counter/display/pattern block for the clk_2 lab top level.
- Contains a parametrised modulo up/down counter with parallel load, enable and terminal-count output.
- Count value drives a multi-digit hex 7-segment encoder.
- An independent serial pattern detector has a parametrised pattern, overlapping matches and a saturating match counter.

---
 rtl/counter_seq_detector.sv | 136 +++++++++++++
 tb/tb_counter_seq_detector.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_detector.sv
// Modulo up/down counter with hex 7-segment display, plus an independent serial pattern detector.
// Define SEG_BLANK_EN to blank leading zero digits (digit 0 always shown).
module counter_seq_detector #(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   MAX_COUNT = {WIDTH{1'b1}},
    parameter int unsigned        NDIGITS   = (WIDTH + 3) / 4,
    parameter int unsigned        PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1101,
    parameter int unsigned        MCNT_W    = 8
) (
    input  logic                   clk_2,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   down,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    input  logic                   ser_in,
    input  logic                   ser_valid,
    output logic [WIDTH-1:0]       count,
    output logic                   tc,
    output logic [8*NDIGITS-1:0]   seg,
    output logic                   match,
    output logic [MCNT_W-1:0]      match_cnt
);

    localparam int unsigned PADW   = 4 * NDIGITS;
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    logic [WIDTH-1:0]     count_next;
    logic [PADW-1:0]      count_pad;
    logic [8*NDIGITS-1:0] seg_next;
    logic [PAT_LEN-1:0]   hist;
    logic [PAT_LEN-1:0]   hist_next;
    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    fill_next;
    logic                 match_next;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'h3F;
            4'h1: hex7 = 8'h06;
            4'h2: hex7 = 8'h5B;
            4'h3: hex7 = 8'h4F;
            4'h4: hex7 = 8'h66;
            4'h5: hex7 = 8'h6D;
            4'h6: hex7 = 8'h7D;
            4'h7: hex7 = 8'h07;
            4'h8: hex7 = 8'h7F;
            4'h9: hex7 = 8'h67;
            4'hA: hex7 = 8'h77;
            4'hB: hex7 = 8'h7C;
            4'hC: hex7 = 8'h39;
            4'hD: hex7 = 8'h5E;
            4'hE: hex7 = 8'h79;
            default: hex7 = 8'h71;
        endcase
    endfunction

    // Load clamps to MAX_COUNT; counting wraps inside 0..MAX_COUNT.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
        end else if (en) begin
            if (down) begin
                count_next = (count == '0) ? MAX_COUNT : count - WIDTH'(1);
            end else begin
                count_next = (count == MAX_COUNT) ? '0 : count + WIDTH'(1);
            end
        end
    end

    assign tc = en & ~load & ((~down & (count == MAX_COUNT)) | (down & (count == '0)));

    assign count_pad = PADW'(count);

    // Digits are walked from the top so blanking can track "all higher digits zero".
    always_comb begin
`ifdef SEG_BLANK_EN
        logic upper_zero;
        upper_zero = 1'b1;
`endif
        seg_next = '0;
        for (int unsigned k = NDIGITS; k > 0; k--) begin
`ifdef SEG_BLANK_EN
            upper_zero = upper_zero & (count_pad[4*(k-1) +: 4] == 4'h0);
            if (upper_zero && (k > 1)) begin
                seg_next[8*(k-1) +: 8] = 8'h00;
            end else begin
                seg_next[8*(k-1) +: 8] = hex7(count_pad[4*(k-1) +: 4]);
            end
`else
            seg_next[8*(k-1) +: 8] = hex7(count_pad[4*(k-1) +: 4]);
`endif
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count <= '0;
            seg   <= {NDIGITS{8'h3F}};
        end else begin
            count <= count_next;
            seg   <= seg_next;
        end
    end

    // Match is judged on the post-shift history so it rises the cycle after the completing bit.
    always_comb begin
        hist_next  = hist;
        fill_next  = fill;
        match_next = 1'b0;
        if (ser_valid) begin
            hist_next  = PAT_LEN'({hist, ser_in});
            fill_next  = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);
            match_next = (fill_next == FILL_W'(PAT_LEN)) && (hist_next == PATTERN);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist  <= hist_next;
            fill  <= fill_next;
            match <= match_next;
            if (match_next && (match_cnt != '1)) begin
                match_cnt <= match_cnt + MCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_detector.sv
// Bench for counter_seq_detector: three parameterisations share one stimulus stream,
// checked every cycle against a behavioural model plus literal expectations.
module tb_counter_seq_detector;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       en;
    logic       down;
    logic       load;
    logic [7:0] load_val;
    logic       ser_in;
    logic       ser_valid;

    logic [7:0]  cnt_a, cnt_c;
    logic [3:0]  cnt_b;
    logic        tc_a, tc_b, tc_c;
    logic [15:0] seg_a, seg_c;
    logic [7:0]  seg_b;
    logic        match_a, match_b, match_c;
    logic [7:0]  mc_a, mc_c;
    logic [1:0]  mc_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk_2 = ~clk_2;

    counter_seq_detector dut_a (
        .clk_2(clk_2), .reset(reset), .en(en), .down(down), .load(load),
        .load_val(load_val), .ser_in(ser_in), .ser_valid(ser_valid),
        .count(cnt_a), .tc(tc_a), .seg(seg_a), .match(match_a), .match_cnt(mc_a)
    );

    counter_seq_detector #(.WIDTH(4), .MAX_COUNT(4'd9), .MCNT_W(2)) dut_b (
        .clk_2(clk_2), .reset(reset), .en(en), .down(down), .load(load),
        .load_val(load_val[3:0]), .ser_in(ser_in), .ser_valid(ser_valid),
        .count(cnt_b), .tc(tc_b), .seg(seg_b), .match(match_b), .match_cnt(mc_b)
    );

    counter_seq_detector #(.WIDTH(8), .MAX_COUNT(8'd199), .PAT_LEN(3), .PATTERN(3'b101)) dut_c (
        .clk_2(clk_2), .reset(reset), .en(en), .down(down), .load(load),
        .load_val(load_val), .ser_in(ser_in), .ser_valid(ser_valid),
        .count(cnt_c), .tc(tc_c), .seg(seg_c), .match(match_c), .match_cnt(mc_c)
    );

    // Per-instance configuration as the model sees it.
    int    cfg_w   [3] = '{8, 4, 8};
    int    cfg_max [3] = '{255, 9, 199};
    int    cfg_cmax[3] = '{255, 3, 255};
    int    cfg_plen[3] = '{4, 4, 3};
    int    cfg_pat [3] = '{13, 13, 5};
    string cfg_nm  [3] = '{"a", "b", "c"};

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h67, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int m_cnt [3] = '{0, 0, 0};
    int m_segv[3] = '{0, 0, 0};
    int m_mc  [3] = '{0, 0, 0};
    bit m_match[3] = '{0, 0, 0};
    bit m_segrst = 1'b1;
    bit rx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] seg_of(input int v, input int nd);
        logic [15:0] r;
        bit          lead;
        int          nib;
        r    = '0;
        lead = 1'b1;
        for (int k = nd - 1; k >= 0; k--) begin
            nib = (v >> (4 * k)) & 15;
`ifdef SEG_BLANK_EN
            if (lead && (k > 0) && (nib == 0)) begin
                r[8*k +: 8] = 8'h00;
            end else begin
                r[8*k +: 8] = hex_tab[nib];
                lead = 1'b0;
            end
`else
            r[8*k +: 8] = hex_tab[nib];
`endif
        end
        return r;
    endfunction

    function automatic bit window_hit(input int len, input int pat);
        int n;
        n = rx.size();
        if (n < len) return 1'b0;
        for (int j = 0; j < len; j++) begin
            if (int'(rx[n - len + j]) != ((pat >> (len - 1 - j)) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i]   = 0;
                m_segv[i]  = 0;
                m_mc[i]    = 0;
                m_match[i] = 1'b0;
            end
            m_segrst = 1'b1;
            rx.delete();
        end else begin
            if (ser_valid) begin
                rx.push_back(ser_in);
                if (rx.size() > 16) void'(rx.pop_front());
            end
            m_segrst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                int lv;
                m_segv[i] = m_cnt[i];
                lv = int'(load_val) & ((1 << cfg_w[i]) - 1);
                if (load) begin
                    m_cnt[i] = (lv > cfg_max[i]) ? cfg_max[i] : lv;
                end else if (en && down) begin
                    m_cnt[i] = (m_cnt[i] == 0) ? cfg_max[i] : m_cnt[i] - 1;
                end else if (en) begin
                    m_cnt[i] = (m_cnt[i] == cfg_max[i]) ? 0 : m_cnt[i] + 1;
                end
                m_match[i] = ser_valid && window_hit(cfg_plen[i], cfg_pat[i]);
                if (m_match[i] && (m_mc[i] < cfg_cmax[i])) m_mc[i]++;
            end
        end
    end

    task automatic cmp(input int i, input int c, input bit t, input logic [15:0] s,
                       input bit m, input int mc);
        int          nd;
        bit          t_exp;
        logic [15:0] s_exp;
        nd    = (cfg_w[i] + 3) / 4;
        t_exp = en && !load && ((!down && m_cnt[i] == cfg_max[i]) || (down && m_cnt[i] == 0));
        s_exp = m_segrst ? ((nd == 2) ? 16'h3F3F : 16'h003F) : seg_of(m_segv[i], nd);
        check({cfg_nm[i], ".count"}, c, m_cnt[i]);
        check({cfg_nm[i], ".tc"}, 32'(t), 32'(t_exp));
        check({cfg_nm[i], ".seg"}, 32'(s), 32'(s_exp));
        check({cfg_nm[i], ".match"}, 32'(m), 32'(m_match[i]));
        check({cfg_nm[i], ".match_cnt"}, mc, m_mc[i]);
    endtask

    always @(negedge clk_2) begin
        cmp(0, int'(cnt_a), tc_a, seg_a, match_a, int'(mc_a));
        cmp(1, int'(cnt_b), tc_b, 16'(seg_b), match_b, int'(mc_b));
        cmp(2, int'(cnt_c), tc_c, seg_c, match_c, int'(mc_c));
    end

    task automatic step();
        @(negedge clk_2);
        #1;
    endtask

    task automatic send_bit(input bit b);
        ser_in    = b;
        ser_valid = 1'b1;
        step();
    endtask

    task automatic gap();
        ser_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; down = 1'b0; load = 1'b0;
        load_val = 8'h00; ser_in = 1'b0; ser_valid = 1'b0;
        step(); step();
        check("lit.reset_count", 32'(cnt_a), 32'h0);
        check("lit.reset_seg_a", 32'(seg_a), 32'h3F3F);
        check("lit.reset_seg_b", 32'(seg_b), 32'h3F);
        check("lit.reset_mc", 32'(mc_a), 32'h0);
        reset = 1'b0;
        step();

        // Overlapping detection, continuous stream 1101101.
        send_bit(1); send_bit(1); send_bit(0); send_bit(1);
        check("lit.match_bit4", 32'(match_a), 32'h1);
        send_bit(1);
        check("lit.match_bit5", 32'(match_a), 32'h0);
        send_bit(0); send_bit(1);
        check("lit.match_bit7", 32'(match_a), 32'h1);
        check("lit.mc_two_a", 32'(mc_a), 32'h2);
        check("lit.mc_two_c", 32'(mc_c), 32'h2);
        ser_valid = 1'b0;

        // Same stream with ser_valid gaps.
        reset = 1'b1; step(); reset = 1'b0;
        send_bit(1); send_bit(1); gap(); send_bit(0); send_bit(1);
        check("lit.gap_match", 32'(match_a), 32'h1);
        gap();
        check("lit.gap_idle", 32'(match_a), 32'h0);
        gap(); send_bit(1); send_bit(0); send_bit(1);
        check("lit.gap_mc", 32'(mc_a), 32'h2);

        // Three more overlapping matches: b saturates at 3.
        for (int r = 0; r < 3; r++) begin
            send_bit(1); send_bit(0); send_bit(1);
        end
        ser_valid = 1'b0;
        check("lit.sat_b", 32'(mc_b), 32'h3);
        check("lit.mc_five_a", 32'(mc_a), 32'h5);

        // Asynchronous reset in the middle of counting.
        load_val = 8'h37; load = 1'b1; step();
        load = 1'b0; en = 1'b1; step(); step();
        check("lit.precount", 32'(cnt_a), 32'h39);
        reset = 1'b1;
        #1;
        check("lit.async_count", 32'(cnt_a), 32'h0);
        check("lit.async_seg", 32'(seg_a), 32'h3F3F);
        check("lit.async_mc", 32'(mc_a), 32'h0);
        step(); step();
        check("lit.reset_hold", 32'(cnt_a), 32'h0);
        reset = 1'b0; en = 1'b0;
        step();

        // Up wrap on the mod-10 counter.
        load_val = 8'h07; load = 1'b1; step();
        check("lit.b_load7", 32'(cnt_b), 32'h7);
        load = 1'b0; en = 1'b1; down = 1'b0; step();
        check("lit.b_8", 32'(cnt_b), 32'h8);
        check("lit.b_tc8", 32'(tc_b), 32'h0);
        step();
        check("lit.b_9", 32'(cnt_b), 32'h9);
        check("lit.b_tc9", 32'(tc_b), 32'h1);
        check("lit.b_seg8", 32'(seg_b), 32'h7F);
        step();
        check("lit.b_wrap", 32'(cnt_b), 32'h0);
        step();
        en = 1'b0; step();
        check("lit.b_seg1", 32'(seg_b), 32'h06);

        // Down wrap and load priority on the default counter.
        load_val = 8'h00; load = 1'b1; step();
        load = 1'b0; en = 1'b1; down = 1'b1;
        #1;
        check("lit.a_tc_down", 32'(tc_a), 32'h1);
        step();
        check("lit.a_ff", 32'(cnt_a), 32'hFF);
        check("lit.c_down_wrap", 32'(cnt_c), 32'd199);
        load = 1'b1; load_val = 8'hA5;
        #1;
        check("lit.a_tc_load", 32'(tc_a), 32'h0);
        step();
        check("lit.a_a5", 32'(cnt_a), 32'hA5);
        load = 1'b0; en = 1'b0; step();
        check("lit.a_seg_a5", 32'(seg_a), 32'h776D);

        // Load clamp.
        load_val = 8'd250; load = 1'b1; step();
        check("lit.c_clamp", 32'(cnt_c), 32'd199);
        check("lit.b_clamp", 32'(cnt_b), 32'd9);
        load = 1'b0; en = 1'b1; down = 1'b0; step();
        check("lit.c_wrap", 32'(cnt_c), 32'h0);
        en = 1'b0;

        // Leading-zero display.
        load_val = 8'h05; load = 1'b1; step();
        load = 1'b0; step();
`ifdef SEG_BLANK_EN
        check("lit.seg_05", 32'(seg_a), 32'h006D);
`else
        check("lit.seg_05", 32'(seg_a), 32'h3F6D);
`endif

        // Mixed traffic, checked by the model only.
        for (int i = 0; i < 48; i++) begin
            en        = (i % 3) != 0;
            down      = ((i / 8) % 2) == 1;
            load      = (i % 13) == 12;
            load_val  = 8'(i * 37);
            ser_in    = ((i * 7) % 5) < 2;
            ser_valid = (i % 4) != 3;
            step();
        end
        en = 1'b0; load = 1'b0; ser_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
